add_pipe: RTL and testbench
===========================

// Module: add_pipe
// PURPOSE
//  Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake on both sides.
//  Successor to the free-running combinational A+B block: adds configurable width and depth,
//  a subtract mode, saturation, carry/overflow flags and backpressure.
//  Sits between operand producers and a result consumer inside the VPI test harness tops.
// PARAMETERS
//  WIDTH   16  operand/result width in bits (>=2)
//  STAGES  2   pipeline depth = latency in cycles (1..4)
//  SAT     0   0: result wraps modulo 2^WIDTH; 1: result clamps on overflow
//  SIGNED  0   0: unsigned operands; 1: two's-complement operands
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b, 1: a-b (sampled with the beat)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts result this cycle
//  c          out  WIDTH  result
//  carry      out  1      unsigned carry-out (add) / borrow (sub), pre-saturation
//  ovf        out  1      result outside representable range for the selected SIGNED mode
// BEHAVIOUR
//  - Reset (rst_n low, async): every stage valid=0, c=0, carry=0, ovf=0, out_valid=0; in_ready=1 after release.
//  - advance = out_ready | ~out_valid; in_ready = advance (combinational). Whole pipe shifts on advance.
//  - Beat accepted when in_valid & in_ready. Result appears on c with out_valid exactly STAGES cycles
//    after acceptance if never stalled; each stall cycle adds one.
//  - Stall (out_valid & ~out_ready): all stage registers and outputs hold; no beat is dropped or duplicated.
//  - Bubbles are carried as invalid stages (no compaction); throughput 1 beat/cycle when unstalled.
//  - Arithmetic in stage 1 on WIDTH+1 bits: sub → a + ~b + 1; carry = bit WIDTH (sub: borrow = ~bit WIDTH).
//  - ovf: SIGNED=0 → carry (add) / borrow (sub); SIGNED=1 → sign of operands equal (add) or differ (sub)
//    and result sign differs from a.
//  - SAT=1 and ovf: unsigned → all-ones (add) / zero (sub); signed → max positive or min negative per a's sign.
//  - Stages 2..STAGES are pure delay registers for c/carry/ovf plus valid.
//  - Reset asserted mid-stream discards all in-flight beats immediately; no partial beat observable.
//  - c/carry/ovf are don't-care-stable (hold last) when out_valid=0; bench checks only on valid.
// CONFIGURATION
//  ADD_PIPE_OVF_CNT_EN defined: extra port ovf_cnt out 16; counts result beats handed off
//   (out_valid & out_ready) with ovf=1; saturates at 16'hFFFF; reset to 0 by rst_n.
//  Not defined: port ovf_cnt and its counter are absent; all other behaviour identical.
// TESTING
//  1. WIDTH=16,STAGES=2: a=10,b=20,sub=0, out_ready=1 → c=30 valid on cycle 2 after accept, carry=0, ovf=0.
//  2. Stream a=1..8, b=0, out_ready held low cycles 3-5 → in_ready low on those cycles; outputs 1..8 in
//     order, none lost or repeated.
//  3. SAT=0 unsigned: a=16'hFFFF,b=1 → c=0, carry=1, ovf=1; SAT=1 same → c=16'hFFFF, ovf=1.
//  4. SIGNED=1,SAT=1: a=16'h7FFF,b=1 → c=16'h7FFF, ovf=1; sub a=16'h8000,b=1 → c=16'h8000, ovf=1;
//     sub a=5,b=7 → c=16'hFFFE, ovf=0.
//  5. Three beats in flight, pulse rst_n low mid-cycle → out_valid drops immediately; after release
//     no stale results emerge, next beat a=3,b=4 → c=7.
//  6. ADD_PIPE_OVF_CNT_EN: 5 overflowing beats, one stalled 3 cycles → ovf_cnt=5 (stall counted once).

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined two-operand adder/subtractor with valid/ready handshake.
// Stage 1 does the WIDTH+1 bit add/sub, flag generation and optional clamp.
// Stages 2..STAGES are plain delay registers. The whole pipe advances when the
// output slot is empty or being consumed.
// Optional feature macro: ADD_PIPE_OVF_CNT_EN adds a saturating 16-bit count
// of handed-off result beats that carried ovf=1.
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SAT    = 0,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf
`ifdef ADD_PIPE_OVF_CNT_EN
  ,
  output logic [15:0]      ovf_cnt
`endif
);

  logic             advance;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic             ov;
  logic             sa;
  logic             sb;
  logic             sr;

  logic             vld_q [STAGES];
  logic [WIDTH-1:0] c_q   [STAGES];
  logic             cy_q  [STAGES];
  logic             ov_q  [STAGES];

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign c         = c_q[STAGES-1];
  assign carry     = cy_q[STAGES-1];
  assign ovf       = ov_q[STAGES-1];

  // Stage-1 arithmetic: add or two's-complement subtract, flags, optional clamp.
  always_comb begin
    b_op = sub ? ~b : b;
    sum  = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    cy   = sub ? ~sum[WIDTH] : sum[WIDTH];
    sa   = a[WIDTH-1];
    sb   = b[WIDTH-1];
    sr   = sum[WIDTH-1];
    if (SIGNED != 0) begin
      ov = (sub ? (sa != sb) : (sa == sb)) && (sr != sa);
    end else begin
      ov = cy;
    end
    res = sum[WIDTH-1:0];
    if ((SAT != 0) && ov) begin
      if (SIGNED != 0) begin
        res = sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        res = sub ? '0 : '1;
      end
    end
  end

  // Pipeline registers; data of a stage only loads when a valid beat enters it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        vld_q[s] <= 1'b0;
        c_q[s]   <= '0;
        cy_q[s]  <= 1'b0;
        ov_q[s]  <= 1'b0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        c_q[0]  <= res;
        cy_q[0] <= cy;
        ov_q[0] <= ov;
      end
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          c_q[s]  <= c_q[s-1];
          cy_q[s] <= cy_q[s-1];
          ov_q[s] <= ov_q[s-1];
        end
      end
    end
  end

`ifdef ADD_PIPE_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  assign ovf_cnt = ovf_cnt_q;

  // Count overflowing beats at hand-off only, so a stalled beat counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= 16'h0000;
    end else if (out_valid && out_ready && ovf && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: three instances (wrap/unsigned, saturating
// unsigned, saturating signed) share one stimulus stream; each has its own
// expected-result queue drained by a monitor on the falling edge.
module tb_add_pipe;

  typedef struct packed {
    logic [17:0] r;     // {c, carry, ovf}
    logic        lat;   // check latency for this beat
    logic [31:0] cyc;   // cycle count at acceptance
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [17:0] w;
    logic [17:0] u;
    logic [17:0] s;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_ready;

  logic        in_ready_w, in_ready_u, in_ready_s;
  logic        ov_w, ov_u, ov_s;
  logic [15:0] c_w, c_u, c_s;
  logic        cy_w, cy_u, cy_s;
  logic        of_w, of_u, of_s;
`ifdef ADD_PIPE_OVF_CNT_EN
  logic [15:0] cnt_w, cnt_u, cnt_s;
`endif

  int          tests;
  int          fails;
  logic [31:0] cyc;
  exp_t        q_w[$];
  exp_t        q_u[$];
  exp_t        q_s[$];
  vec_t        tbl[8];

  add_pipe #(.WIDTH(16), .STAGES(2), .SAT(0), .SIGNED(0)) u_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .sub(sub), .out_valid(ov_w), .out_ready(out_ready),
    .c(c_w), .carry(cy_w), .ovf(of_w)
`ifdef ADD_PIPE_OVF_CNT_EN
    , .ovf_cnt(cnt_w)
`endif
  );

  add_pipe #(.WIDTH(16), .STAGES(2), .SAT(1), .SIGNED(0)) u_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .a(a), .b(b), .sub(sub), .out_valid(ov_u), .out_ready(out_ready),
    .c(c_u), .carry(cy_u), .ovf(of_u)
`ifdef ADD_PIPE_OVF_CNT_EN
    , .ovf_cnt(cnt_u)
`endif
  );

  add_pipe #(.WIDTH(16), .STAGES(2), .SAT(1), .SIGNED(1)) u_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .sub(sub), .out_valid(ov_s), .out_ready(out_ready),
    .c(c_s), .carry(cy_s), .ovf(of_s)
`ifdef ADD_PIPE_OVF_CNT_EN
    , .ovf_cnt(cnt_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic compare(input string nm, input exp_t e, input logic [15:0] cv,
                         input logic cyv, input logic ofv);
    check({nm, ".c"}, {16'h0, cv}, {16'h0, e.r[17:2]});
    check({nm, ".carry"}, {31'h0, cyv}, {31'h0, e.r[1]});
    check({nm, ".ovf"}, {31'h0, ofv}, {31'h0, e.r[0]});
    if (e.lat) check({nm, ".latency"}, cyc - e.cyc, 32'd2);
  endtask

  // Monitor: every handed-off beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (ov_w && out_ready) begin
      if (q_w.size() == 0) check("wrap.unexpected_beat", 32'd1, 32'd0);
      else compare("wrap", q_w.pop_front(), c_w, cy_w, of_w);
    end
    if (ov_u && out_ready) begin
      if (q_u.size() == 0) check("usat.unexpected_beat", 32'd1, 32'd0);
      else compare("usat", q_u.pop_front(), c_u, cy_u, of_u);
    end
    if (ov_s && out_ready) begin
      if (q_s.size() == 0) check("ssat.unexpected_beat", 32'd1, 32'd0);
      else compare("ssat", q_s.pop_front(), c_s, cy_s, of_s);
    end
  end

  task automatic push(input logic [17:0] w, input logic [17:0] u, input logic [17:0] s,
                      input logic lat);
    q_w.push_back('{r: w, lat: lat, cyc: cyc});
    q_u.push_back('{r: u, lat: lat, cyc: cyc});
    q_s.push_back('{r: s, lat: lat, cyc: cyc});
  endtask

  // Entered and left at posedge+1; waits (bounded) until the beat is accepted.
  task automatic send(input vec_t v, input logic do_push, input logic lat);
    logic acc;
    int   n;
    a        = v.a;
    b        = v.b;
    sub      = v.sub;
    in_valid = 1'b1;
    n        = 0;
    acc      = 1'b0;
    while (!acc && n < 50) begin
      #1;
      acc = in_ready_w;
      @(posedge clk);
      if (acc && do_push) push(v.w, v.u, v.s, lat);
      #1;
      n++;
    end
    if (!acc) check("send.accept_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   k;
    int   i;
    int   n;
    vec_t v;

    tests     = 0;
    fails     = 0;
    cyc       = 32'd0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    sub       = 1'b0;
    out_ready = 1'b1;

    //            a         b         sub   wrap {c,cy,ov}      usat                ssat
    tbl[0] = '{16'h000A, 16'h0014, 1'b0, {16'h001E,2'b00}, {16'h001E,2'b00}, {16'h001E,2'b00}};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, {16'h0000,2'b11}, {16'hFFFF,2'b11}, {16'h0000,2'b10}};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, {16'h8000,2'b00}, {16'h8000,2'b00}, {16'h7FFF,2'b01}};
    tbl[3] = '{16'h8000, 16'h0001, 1'b1, {16'h7FFF,2'b00}, {16'h7FFF,2'b00}, {16'h8000,2'b01}};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, {16'hFFFE,2'b11}, {16'h0000,2'b11}, {16'hFFFE,2'b10}};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, {16'h0000,2'b11}, {16'hFFFF,2'b11}, {16'h8000,2'b11}};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, {16'h0000,2'b00}, {16'h0000,2'b00}, {16'h0000,2'b00}};
    tbl[7] = '{16'h7FFF, 16'h8000, 1'b1, {16'hFFFF,2'b11}, {16'h0000,2'b11}, {16'h7FFF,2'b11}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", {29'h0, ov_w, ov_u, ov_s}, 32'd0);
    check("reset.c", {c_w, c_s}, 32'd0);
    check("reset.flags", {28'h0, cy_w, of_w, cy_s, of_s}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset.in_ready", {29'h0, in_ready_w, in_ready_u, in_ready_s}, 32'd7);
`ifdef ADD_PIPE_OVF_CNT_EN
    check("reset.ovf_cnt", {16'h0, cnt_w}, 32'd0);
`endif
    next_cycle();

    // Directed arithmetic vectors, back to back, no backpressure
    send(tbl[0], 1'b1, 1'b1);
    for (int t = 1; t < 8; t++) send(tbl[t], 1'b1, 1'b0);

    // Stream 1..8 with out_ready low on cycles 3-5
    k = 0;
    i = 1;
    while (i <= 8 && k < 40) begin
      k++;
      out_ready = !(k >= 3 && k <= 5);
      a         = i[15:0];
      b         = 16'h0;
      sub       = 1'b0;
      in_valid  = 1'b1;
      #1;
      if (k >= 3 && k <= 5) check("stall.in_ready", {31'h0, in_ready_w}, 32'd0);
      acc = in_ready_w;
      @(posedge clk);
      if (acc) begin
        push({i[15:0], 2'b00}, {i[15:0], 2'b00}, {i[15:0], 2'b00}, 1'b0);
        i++;
      end
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) next_cycle();

    // Mid-stream reset: fill the pipe under stall, then pulse rst_n mid-cycle
    out_ready = 1'b0;
    v = '{16'h0100, 16'h0001, 1'b0, 18'h0, 18'h0, 18'h0};
    send(v, 1'b0, 1'b0);
    v.a = 16'h0200;
    send(v, 1'b0, 1'b0);
    a        = 16'h0300;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.out_valid", {29'h0, ov_w, ov_u, ov_s}, 32'd0);
    in_valid = 1'b0;
    next_cycle();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      next_cycle();
      check("midreset.no_stale", {29'h0, ov_w, ov_u, ov_s}, 32'd0);
    end
    v = '{16'h0003, 16'h0004, 1'b0, {16'h0007,2'b00}, {16'h0007,2'b00}, {16'h0007,2'b00}};
    send(v, 1'b1, 1'b0);
    repeat (4) next_cycle();

`ifdef ADD_PIPE_OVF_CNT_EN
    // Five overflowing beats, the first stalled at the output for 3 cycles
    check("ovfcnt.before", {16'h0, cnt_w}, 32'd0);
    send(tbl[1], 1'b1, 1'b0);
    send(tbl[1], 1'b1, 1'b0);
    out_ready = 1'b0;
    repeat (3) next_cycle();
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) send(tbl[1], 1'b1, 1'b0);
    repeat (6) next_cycle();
    check("ovfcnt.wrap", {16'h0, cnt_w}, 32'd5);
    check("ovfcnt.usat", {16'h0, cnt_u}, 32'd5);
    check("ovfcnt.ssat", {16'h0, cnt_s}, 32'd0);
`endif

    // Drain and confirm nothing was lost
    n = 0;
    while ((q_w.size() + q_u.size() + q_s.size()) != 0 && n < 50) begin
      next_cycle();
      n++;
    end
    check("drain.queues_empty", q_w.size() + q_u.size() + q_s.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
